// File: rtl/picoctrl_core.sv
// Tiny conditional-write/jump sequencer: one 16-bit ROM instruction per clock,
// four 8-bit output registers, optional 2-flop synchronizer on the condition inputs.
module picoctrl_core #(
  parameter int unsigned SYNC_EN = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic [7:0]  c_in,
  output logic [4:0]  addr,
  input  logic [15:0] data,
  output logic [7:0]  r0,
  output logic [7:0]  r1,
  output logic [7:0]  r2,
  output logic [7:0]  r3,
  output logic [3:0]  wr_stb,
  output logic        jmp_stb
);

  localparam int unsigned CW = 8;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 4;

  localparam logic [1:0] OP_JMP = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;

  logic [CW-1:0]         w_cs;
  logic                  w_v;
  logic [2:0]            w_idx;
  logic [1:0]            w_op;
  logic [1:0]            w_dst;
  logic [7:0]            w_imm;
  logic                  w_cond;
  logic                  w_jump_take;
  logic                  w_write_take;
  logic [NR-1:0]         w_wr_onehot;
  logic [NR-1:0][7:0]    r_regs;

  // Condition source: synchronized copy keeps sampling even while run is low
  if (SYNC_EN != 0) begin : g_sync
    logic [CW-1:0] r_sync1;
    logic [CW-1:0] r_sync2;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_sync1 <= '0;
        r_sync2 <= '0;
      end else begin
        r_sync1 <= c_in;
        r_sync2 <= r_sync1;
      end
    end
    assign w_cs = r_sync2;
  end else begin : g_nosync
    assign w_cs = c_in;
  end

  always_comb begin
    w_v          = data[15];
    w_idx        = data[14:12];
    w_op         = data[11:10];
    w_dst        = data[9:8];
    w_imm        = data[7:0];
    w_cond       = (w_cs[w_idx] == w_v);
    w_jump_take  = w_cond && (w_op == OP_JMP);
    w_write_take = w_cond && (w_op == OP_WR);
    w_wr_onehot  = NR'(1) << w_dst;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr    <= '0;
      r_regs  <= '0;
      wr_stb  <= '0;
      jmp_stb <= 1'b0;
    end else begin
      wr_stb  <= '0;
      jmp_stb <= 1'b0;
      if (run) begin
        // Only imm[4:0] addresses the 32-word ROM
        if (w_jump_take) begin
          addr    <= w_imm[AW-1:0];
          jmp_stb <= 1'b1;
        end else begin
          addr <= addr + AW'(1);
        end
        if (w_write_take) begin
          r_regs[w_dst] <= w_imm;
          wr_stb        <= w_wr_onehot;
        end
      end
    end
  end

  assign r0 = r_regs[0];
  assign r1 = r_regs[1];
  assign r2 = r_regs[2];
  assign r3 = r_regs[3];

endmodule

// File: tb/tb_picoctrl_core.sv
// Directed bench for picoctrl_core: ROM model in the bench, hand-computed expectations.
module tb_picoctrl_core;

  logic        clk;
  logic        reset_n;
  logic        run;
  logic [7:0]  c_in;
  logic [4:0]  addr, addr_n;
  logic [15:0] data, data_n;
  logic [7:0]  r0, r1, r2, r3;
  logic [7:0]  n_r0, n_r1, n_r2, n_r3;
  logic [3:0]  wr_stb, n_wr_stb;
  logic        jmp_stb, n_jmp_stb;
  logic [15:0] rom [32];

  int total = 0;
  int bad   = 0;

  assign data   = rom[addr];
  assign data_n = rom[addr_n];

  picoctrl_core #(.SYNC_EN(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .run(run), .c_in(c_in), .addr(addr), .data(data),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .wr_stb(wr_stb), .jmp_stb(jmp_stb)
  );

  picoctrl_core #(.SYNC_EN(0)) u_nosync (
    .clk(clk), .reset_n(reset_n), .run(run), .c_in(c_in), .addr(addr_n), .data(data_n),
    .r0(n_r0), .r1(n_r1), .r2(n_r2), .r3(n_r3), .wr_stb(n_wr_stb), .jmp_stb(n_jmp_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 32; i++) rom[i] = 16'h8000;
  endtask

  // Short asynchronous pulse placed between clock edges
  task automatic apply_reset();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    fill_nop();
    rom[0] = 16'h0471;
    c_in = 8'h00;
    run = 1'b1;
    reset_n = 1'b0;
    repeat (3) tick();
    total++; if (addr !== 5'd0) begin bad++; $display("FAIL reset_addr got=%h exp=00", addr); end
    total++; if (r0 !== 8'h00) begin bad++; $display("FAIL reset_r0 got=%h exp=00", r0); end
    total++; if ({r1, r2, r3} !== 24'h0) begin bad++; $display("FAIL reset_r123 got=%h exp=0", {r1, r2, r3}); end
    total++; if ({wr_stb, jmp_stb} !== 5'b0) begin bad++; $display("FAIL reset_stb got=%b exp=00000", {wr_stb, jmp_stb}); end
    #2 reset_n = 1'b1;
    tick();
    total++; if (r0 !== 8'h71) begin bad++; $display("FAIL first_r0 got=%h exp=71", r0); end
    total++; if (wr_stb !== 4'b0001) begin bad++; $display("FAIL first_wr_stb got=%b exp=0001", wr_stb); end
    total++; if (addr !== 5'd1) begin bad++; $display("FAIL first_addr got=%h exp=01", addr); end
  endtask

  task automatic test_wait_loop();
    fill_nop();
    rom[1] = 16'hD001;
    c_in = 8'h20;
    run = 1'b0;
    apply_reset();
    repeat (3) tick();
    total++; if (addr !== 5'd0 || jmp_stb !== 1'b0) begin bad++; $display("FAIL presync_hold got=%h/%b exp=00/0", addr, jmp_stb); end
    run = 1'b1;
    tick();
    total++; if (addr !== 5'd1) begin bad++; $display("FAIL loop_entry got=%h exp=01", addr); end
    repeat (3) begin
      tick();
      total++; if (addr !== 5'd1 || jmp_stb !== 1'b1) begin bad++; $display("FAIL loop_hold got=%h/%b exp=01/1", addr, jmp_stb); end
    end
    c_in = 8'h00;
    tick();
    tick();
    total++; if (addr !== 5'd1 || jmp_stb !== 1'b1) begin bad++; $display("FAIL loop_sync_lag got=%h/%b exp=01/1", addr, jmp_stb); end
    tick();
    total++; if (addr !== 5'd2 || jmp_stb !== 1'b0) begin bad++; $display("FAIL loop_exit got=%h/%b exp=02/0", addr, jmp_stb); end
  endtask

  task automatic test_wrap_nop();
    fill_nop();
    c_in = 8'h00;
    run = 1'b1;
    apply_reset();
    total++; if (addr !== 5'd0) begin bad++; $display("FAIL wrap_start got=%h exp=00", addr); end
    for (int k = 1; k <= 33; k++) begin
      tick();
      total++; if (addr !== 5'(k % 32)) begin bad++; $display("FAIL wrap_addr step=%0d got=%h exp=%h", k, addr, 5'(k % 32)); end
      total++; if ({wr_stb, jmp_stb} !== 5'b0) begin bad++; $display("FAIL wrap_stb step=%0d got=%b exp=00000", k, {wr_stb, jmp_stb}); end
    end
  endtask

  task automatic test_jump_mask();
    fill_nop();
    rom[0] = 16'h00E3;
    c_in = 8'h00;
    run = 1'b1;
    apply_reset();
    tick();
    total++; if (addr !== 5'd3 || jmp_stb !== 1'b1) begin bad++; $display("FAIL jmp_mask got=%h/%b exp=03/1", addr, jmp_stb); end
    total++; if (wr_stb !== 4'b0) begin bad++; $display("FAIL jmp_excl got=%b exp=0000", wr_stb); end
    tick();
    total++; if (addr !== 5'd4 || jmp_stb !== 1'b0) begin bad++; $display("FAIL jmp_after got=%h/%b exp=04/0", addr, jmp_stb); end
  endtask

  task automatic test_hold();
    fill_nop();
    rom[0] = 16'h0411;
    rom[1] = 16'h0522;
    rom[2] = 16'h0633;
    rom[3] = 16'h0744;
    c_in = 8'h00;
    run = 1'b1;
    apply_reset();
    tick();
    tick();
    total++; if (addr !== 5'd2 || wr_stb !== 4'b0010) begin bad++; $display("FAIL hold_pre got=%h/%b exp=02/0010", addr, wr_stb); end
    run = 1'b0;
    repeat (5) begin
      tick();
      total++; if (addr !== 5'd2) begin bad++; $display("FAIL hold_addr got=%h exp=02", addr); end
      total++; if ({r0, r1, r2, r3} !== 32'h1122_0000) begin bad++; $display("FAIL hold_regs got=%h exp=11220000", {r0, r1, r2, r3}); end
      total++; if ({wr_stb, jmp_stb} !== 5'b0) begin bad++; $display("FAIL hold_stb got=%b exp=00000", {wr_stb, jmp_stb}); end
    end
    run = 1'b1;
    tick();
    total++; if (addr !== 5'd3 || r2 !== 8'h33 || wr_stb !== 4'b0100) begin bad++; $display("FAIL resume_r2 got=%h/%h/%b exp=03/33/0100", addr, r2, wr_stb); end
    tick();
    total++; if ({r0, r1, r2, r3} !== 32'h1122_3344 || wr_stb !== 4'b1000 || addr !== 5'd4) begin bad++; $display("FAIL resume_r3 got=%h/%b/%h exp=11223344/1000/04", {r0, r1, r2, r3}, wr_stb, addr); end
  endtask

  task automatic test_reset_in_loop();
    fill_nop();
    rom[0] = 16'h075A;
    rom[1] = 16'hD001;
    c_in = 8'h20;
    run = 1'b0;
    apply_reset();
    repeat (3) tick();
    run = 1'b1;
    tick();
    total++; if (r3 !== 8'h5A || addr !== 5'd1) begin bad++; $display("FAIL rl_write got=%h/%h exp=5a/01", r3, addr); end
    tick();
    total++; if (addr !== 5'd1 || jmp_stb !== 1'b1) begin bad++; $display("FAIL rl_loop got=%h/%b exp=01/1", addr, jmp_stb); end
    #2 reset_n = 1'b0;
    #1;
    total++; if ({addr, r0, r1, r2, r3, wr_stb, jmp_stb} !== 42'h0) begin bad++; $display("FAIL rl_async got=%h exp=0", {addr, r0, r1, r2, r3, wr_stb, jmp_stb}); end
    #1 reset_n = 1'b1;
    tick();
    total++; if (addr !== 5'd1 || r3 !== 8'h5A || wr_stb !== 4'b1000) begin bad++; $display("FAIL rl_restart got=%h/%h/%b exp=01/5a/1000", addr, r3, wr_stb); end
    tick();
    total++; if (addr !== 5'd2 || jmp_stb !== 1'b0) begin bad++; $display("FAIL rl_sync_cleared got=%h/%b exp=02/0", addr, jmp_stb); end
  endtask

  task automatic test_nosync();
    fill_nop();
    rom[0] = 16'hD000;
    c_in = 8'h20;
    run = 1'b1;
    apply_reset();
    tick();
    total++; if (addr_n !== 5'd0 || n_jmp_stb !== 1'b1) begin bad++; $display("FAIL nosync_loop got=%h/%b exp=00/1", addr_n, n_jmp_stb); end
    total++; if (addr !== 5'd1 || jmp_stb !== 1'b0) begin bad++; $display("FAIL sync_lag got=%h/%b exp=01/0", addr, jmp_stb); end
    c_in = 8'h00;
    tick();
    total++; if (addr_n !== 5'd1 || n_jmp_stb !== 1'b0) begin bad++; $display("FAIL nosync_exit got=%h/%b exp=01/0", addr_n, n_jmp_stb); end
  endtask

  initial begin
    reset_n = 1'b0;
    run = 1'b0;
    c_in = 8'h00;
    fill_nop();
    test_reset();
    test_wait_loop();
    test_wrap_nop();
    test_jump_mask();
    test_hold();
    test_reset_in_loop();
    test_nosync();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/picoctrl_core.md
PICOCTRL_CORE -- requirements
Module: picoctrl_core

Interface
REQ-001 The block SHALL have parameter SYNC_EN, default 1, meaning: 1 = c_in passes through a 2-flop synchronizer, 0 = c_in is sampled directly.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all flops SHALL be rising-edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port run, input, 1 bit: 1 = execute one instruction per clock, 0 = hold.
REQ-005 The block SHALL have port c_in, input, 8 bits: external condition inputs c0..c7.
REQ-006 The block SHALL have port addr, output, 5 bits: program counter, driving the instruction ROM address.
REQ-007 The block SHALL have port data, input, 16 bits: instruction word returned combinationally by the ROM for addr.
REQ-008 The block SHALL have ports r0, r1, r2 and r3, outputs, 8 bits each: registered output ports.
REQ-009 The block SHALL have port wr_stb, output, 4 bits: one-cycle pulse on bit n when rn is written.
REQ-010 The block SHALL have port jmp_stb, output, 1 bit: one-cycle pulse when a jump is taken.

Function
REQ-011 The decoder SHALL split data as follows: data[15] = compare value v, data[14:12] = condition index i, data[11:10] = opcode, data[9:8] = destination register, data[7:0] = immediate.
REQ-012 The condition SHALL be true when cs[i] == v, where cs is the synchronized c_in when SYNC_EN = 1, else the raw c_in.
REQ-013 Opcode 01 (write) with a true condition SHALL load the immediate into r[data[9:8]] at the clock edge and SHALL set wr_stb[data[9:8]] = 1 for that one cycle.
REQ-014 Opcode 00 (jump) with a true condition SHALL load addr with immediate[4:0]; immediate[7:5] SHALL be ignored, and jmp_stb SHALL be 1 for one cycle.
REQ-015 Opcodes 10 and 11, and any instruction whose condition is false, SHALL execute as no-operations; the word 16'h8000 is the canonical NOP.
REQ-016 Every executed instruction other than a taken jump SHALL advance addr by 1, with modulo-32 wrap from 31 to 0.
REQ-017 Each instruction SHALL take one cycle; the effect of the data presented during cycle k SHALL be visible on the outputs after edge k+1.
REQ-018 When run = 0, addr, r0..r3 and the synchronizer SHALL keep their values, except that the synchronizer SHALL keep sampling; wr_stb and jmp_stb SHALL be 0.
REQ-019 A taken jump to its own address SHALL hold addr at that address (wait loop) until the condition becomes false, after which addr SHALL advance by 1.
REQ-020 A change on c_in SHALL affect the condition evaluation 2 cycles later when SYNC_EN = 1, and in the same cycle when SYNC_EN = 0.
REQ-021 A write to a register SHALL update only the addressed register; the other three registers SHALL hold.
REQ-022 At most one strobe bit across wr_stb and jmp_stb SHALL be 1 in any cycle.

Reset
REQ-023 While reset_n = 0, addr, r0, r1, r2, r3, wr_stb, jmp_stb and both synchronizer stages SHALL be 0, regardless of clk.
REQ-024 Assertion of reset_n mid-program SHALL take effect immediately; after deassertion, the first executed instruction SHALL be at address 0.
REQ-025 No output SHALL be X after reset.

Verification
REQ-026 Reset test: with reset_n = 0, run = 1 and ROM[0] = {0000,01,00,8'h71} held, check addr = 0 and r0 = 0. Release reset with c_in = 0 and check after one edge: r0 = 8'h71, wr_stb = 4'b0001, addr = 1.
REQ-027 Wait-loop test: with ROM[1] = {1101,00,00,8'h01} and c5 = 1, addr SHALL stay at 1 with jmp_stb = 1 each cycle. Drop c5 to 0 and check addr = 2 exactly 3 edges later (SYNC_EN = 1).
REQ-028 Wrap and NOP test: load a ROM of all 16'h8000 with c0 = 0 and check addr counts 0..31, then 0, with no strobes firing.
REQ-029 Jump-masking test: execute jump immediate 8'hE3 with the condition true and check addr = 3.
REQ-030 Hold test: deassert run for 5 cycles in the middle of a write sequence and check addr and r0..r3 are frozen, strobes are 0, and execution resumes at the same address.
REQ-031 Reset-during-loop test: pulse reset_n low asynchronously between clock edges while in a wait loop and check all outputs are 0 at once and execution restarts at address 0.
